// File: rtl/host_fifo_agent.sv
`default_nettype none
// ---------------------------------------------------------------------------
// host_fifo_agent : packs host commands into the command FIFO and decodes
// response words into shadow channel/TX/RX registers.   Rev 1.0
// ---------------------------------------------------------------------------
module host_fifo_agent (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_kind_i,
  input  logic [31:0] cmd_data_i,
  output logic        cmd_err_o,
  input  logic        cmd_fifo_full_i,
  output logic [33:0] cmd_fifo_wdata_o,
  output logic        cmd_fifo_winc_o,
  input  logic        rsp_fifo_empty_i,
  input  logic [33:0] rsp_fifo_rdata_i,
  output logic        rsp_fifo_rinc_o,
  output logic        sh_channel_o,
  output logic [15:0] sh_tx_config_o,
  output logic        sh_tx_status_o,
  output logic [15:0] sh_rx_config_o,
  output logic [15:0] sh_rx_status_o,
  output logic [31:0] sh_rx_data_o,
  output logic        upd_channel_o,
  output logic        upd_tx_config_o,
  output logic        upd_tx_status_o,
  output logic        upd_rx_config_o,
  output logic        upd_rx_status_o,
  output logic        rx_data_valid_o
);

  localparam logic [1:0] C_MOD_CONFIG  = 2'd0;
  localparam logic [1:0] C_MOD_DATA    = 2'd1;
  localparam logic [1:0] C_MOD_STATUS  = 2'd2;
  localparam logic [1:0] C_MOD_CHANNEL = 2'd3;

  typedef enum logic [1:0] {C_IDLE = 2'd0, C_HOLD = 2'd1, C_WRITE = 2'd2} cmd_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_POP = 1'b1} rsp_state_t;

  cmd_state_t  cmd_state_q;
  rsp_state_t  rsp_state_q;
  logic [33:0] wdata_q;
  logic        winc_q;
  logic        err_q;

  logic        rinc_q;
  logic        channel_q;
  logic [15:0] tx_config_q;
  logic        tx_status_q;
  logic [15:0] rx_config_q;
  logic [15:0] rx_status_q;
  logic [31:0] rx_data_q;
  logic        upd_channel_q;
  logic        upd_tx_config_q;
  logic        upd_tx_status_q;
  logic        upd_rx_config_q;
  logic        upd_rx_status_q;
  logic        rx_data_valid_q;

  logic [1:0]  w_rsp_mod;
  logic [31:0] w_rsp_data;

  assign w_rsp_mod  = rsp_fifo_rdata_i[33:32];
  assign w_rsp_data = rsp_fifo_rdata_i[31:0];

  // Command path: STATUS is not a writable register, so it is swallowed with an error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_state_q <= C_IDLE;
      wdata_q     <= 34'd0;
      winc_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      winc_q <= 1'b0;
      err_q  <= 1'b0;
      case (cmd_state_q)
        C_IDLE: begin
          if (cmd_valid_i) begin
            if (cmd_kind_i == C_MOD_STATUS) begin
              err_q <= 1'b1;
            end else begin
              wdata_q     <= {cmd_kind_i, cmd_data_i};
              cmd_state_q <= C_HOLD;
            end
          end
        end
        C_HOLD: begin
          if (!cmd_fifo_full_i) begin
            winc_q      <= 1'b1;
            cmd_state_q <= C_WRITE;
          end
        end
        C_WRITE: cmd_state_q <= C_IDLE;
        default: cmd_state_q <= C_IDLE;
      endcase
    end
  end

  // Response path: routing of STATUS/CONFIG uses the channel confirmed before this word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_state_q     <= R_IDLE;
      rinc_q          <= 1'b0;
      channel_q       <= 1'b0;
      tx_config_q     <= 16'd0;
      tx_status_q     <= 1'b0;
      rx_config_q     <= 16'd0;
      rx_status_q     <= 16'd0;
      rx_data_q       <= 32'd0;
      upd_channel_q   <= 1'b0;
      upd_tx_config_q <= 1'b0;
      upd_tx_status_q <= 1'b0;
      upd_rx_config_q <= 1'b0;
      upd_rx_status_q <= 1'b0;
      rx_data_valid_q <= 1'b0;
    end else begin
      rinc_q          <= 1'b0;
      upd_channel_q   <= 1'b0;
      upd_tx_config_q <= 1'b0;
      upd_tx_status_q <= 1'b0;
      upd_rx_config_q <= 1'b0;
      upd_rx_status_q <= 1'b0;
      rx_data_valid_q <= 1'b0;
      case (rsp_state_q)
        R_IDLE: begin
          if (!rsp_fifo_empty_i) begin
            rinc_q      <= 1'b1;
            rsp_state_q <= R_POP;
            case (w_rsp_mod)
              C_MOD_CHANNEL: begin
                channel_q     <= w_rsp_data[0];
                upd_channel_q <= 1'b1;
              end
              C_MOD_DATA: begin
                rx_data_q       <= w_rsp_data;
                rx_data_valid_q <= 1'b1;
              end
              C_MOD_STATUS: begin
                if (channel_q) begin
                  rx_status_q     <= w_rsp_data[15:0];
                  upd_rx_status_q <= 1'b1;
                end else begin
                  tx_status_q     <= w_rsp_data[0];
                  upd_tx_status_q <= 1'b1;
                end
              end
              default: begin
                if (channel_q) begin
                  rx_config_q     <= w_rsp_data[15:0];
                  upd_rx_config_q <= 1'b1;
                end else begin
                  tx_config_q     <= w_rsp_data[15:0];
                  upd_tx_config_q <= 1'b1;
                end
              end
            endcase
          end
        end
        default: rsp_state_q <= R_IDLE;
      endcase
    end
  end

  assign cmd_ready_o      = (cmd_state_q == C_IDLE);
  assign cmd_err_o        = err_q;
  assign cmd_fifo_wdata_o = wdata_q;
  assign cmd_fifo_winc_o  = winc_q;
  assign rsp_fifo_rinc_o  = rinc_q;
  assign sh_channel_o     = channel_q;
  assign sh_tx_config_o   = tx_config_q;
  assign sh_tx_status_o   = tx_status_q;
  assign sh_rx_config_o   = rx_config_q;
  assign sh_rx_status_o   = rx_status_q;
  assign sh_rx_data_o     = rx_data_q;
  assign upd_channel_o    = upd_channel_q;
  assign upd_tx_config_o  = upd_tx_config_q;
  assign upd_tx_status_o  = upd_tx_status_q;
  assign upd_rx_config_o  = upd_rx_config_q;
  assign upd_rx_status_o  = upd_rx_status_q;
  assign rx_data_valid_o  = rx_data_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_host_fifo_agent.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_host_fifo_agent : directed checks of command and response paths.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_host_fifo_agent;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_kind = 2'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        cmd_err;
  logic        cmd_fifo_full = 1'b0;
  logic [33:0] cmd_fifo_wdata;
  logic        cmd_fifo_winc;
  logic        rsp_fifo_empty = 1'b1;
  logic [33:0] rsp_fifo_rdata = 34'd0;
  logic        rsp_fifo_rinc;
  logic        sh_channel;
  logic [15:0] sh_tx_config;
  logic        sh_tx_status;
  logic [15:0] sh_rx_config;
  logic [15:0] sh_rx_status;
  logic [31:0] sh_rx_data;
  logic        upd_channel, upd_tx_config, upd_tx_status;
  logic        upd_rx_config, upd_rx_status, rx_data_valid;

  int n_checks = 0;
  int n_errors = 0;

  host_fifo_agent dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid_i      (cmd_valid),
    .cmd_ready_o      (cmd_ready),
    .cmd_kind_i       (cmd_kind),
    .cmd_data_i       (cmd_data),
    .cmd_err_o        (cmd_err),
    .cmd_fifo_full_i  (cmd_fifo_full),
    .cmd_fifo_wdata_o (cmd_fifo_wdata),
    .cmd_fifo_winc_o  (cmd_fifo_winc),
    .rsp_fifo_empty_i (rsp_fifo_empty),
    .rsp_fifo_rdata_i (rsp_fifo_rdata),
    .rsp_fifo_rinc_o  (rsp_fifo_rinc),
    .sh_channel_o     (sh_channel),
    .sh_tx_config_o   (sh_tx_config),
    .sh_tx_status_o   (sh_tx_status),
    .sh_rx_config_o   (sh_rx_config),
    .sh_rx_status_o   (sh_rx_status),
    .sh_rx_data_o     (sh_rx_data),
    .upd_channel_o    (upd_channel),
    .upd_tx_config_o  (upd_tx_config),
    .upd_tx_status_o  (upd_tx_status),
    .upd_rx_config_o  (upd_rx_config),
    .upd_rx_status_o  (upd_rx_status),
    .rx_data_valid_o  (rx_data_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe vector {upd_channel, rx_data_valid, upd_rx_status, upd_rx_config, upd_tx_status, upd_tx_config}
  function automatic logic [5:0] strobes();
    return {upd_channel, rx_data_valid, upd_rx_status, upd_rx_config, upd_tx_status, upd_tx_config};
  endfunction

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_winc", cmd_fifo_winc, 0);
    chk("rst_wdata", cmd_fifo_wdata, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_rinc", rsp_fifo_rinc, 0);
    chk("rst_strobes", strobes(), 0);
    chk("rst_shadows", {sh_channel, sh_tx_config, sh_tx_status, sh_rx_config, sh_rx_status}, 0);
    chk("rst_rxdata", sh_rx_data, 0);
    rst = 1'b0;
    tick();

    // Basic DATA command
    cmd_valid = 1'b1; cmd_kind = 2'd1; cmd_data = 32'hDEADBEEF;
    chk("c1_ready_pre", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("c1_ready_hold", cmd_ready, 0);
    chk("c1_winc_hold", cmd_fifo_winc, 0);
    tick();
    chk("c1_ready_write", cmd_ready, 0);
    chk("c1_winc", cmd_fifo_winc, 1);
    chk("c1_wdata", cmd_fifo_wdata, {2'b01, 32'hDEADBEEF});
    tick();
    chk("c1_winc_off", cmd_fifo_winc, 0);
    chk("c1_ready_back", cmd_ready, 1);

    // CHANNEL command stalled by full FIFO
    cmd_valid = 1'b1; cmd_kind = 2'd3; cmd_data = 32'h1; cmd_fifo_full = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("c2_full_winc", cmd_fifo_winc, 0);
      chk("c2_full_ready", cmd_ready, 0);
      tick();
    end
    chk("c2_channel_unconfirmed", sh_channel, 0);
    cmd_fifo_full = 1'b0;
    tick();
    chk("c2_winc", cmd_fifo_winc, 1);
    chk("c2_wdata", cmd_fifo_wdata, {2'd3, 32'h1});
    tick();
    chk("c2_winc_off", cmd_fifo_winc, 0);
    chk("c2_ready_back", cmd_ready, 1);

    // Illegal STATUS command, then a CONFIG command
    cmd_valid = 1'b1; cmd_kind = 2'd2; cmd_data = 32'h77;
    tick();
    chk("c3_err", cmd_err, 1);
    chk("c3_ready", cmd_ready, 1);
    chk("c3_winc", cmd_fifo_winc, 0);
    chk("c3_wdata_kept", cmd_fifo_wdata, {2'd3, 32'h1});
    cmd_kind = 2'd0; cmd_data = 32'h0000_00A5;
    tick();
    cmd_valid = 1'b0;
    chk("c3_err_off", cmd_err, 0);
    chk("c3_ready_hold", cmd_ready, 0);
    tick();
    chk("c3_winc2", cmd_fifo_winc, 1);
    chk("c3_wdata2", cmd_fifo_wdata, {2'd0, 32'h0000_00A5});
    tick();

    // Back-to-back responses selecting RX
    rsp_fifo_empty = 1'b0; rsp_fifo_rdata = {2'd3, 32'h1};
    tick();
    chk("r1_rinc", rsp_fifo_rinc, 1);
    chk("r1_strobes", strobes(), 6'b100000);
    chk("r1_channel", sh_channel, 1);
    rsp_fifo_rdata = {2'd1, 32'h12345678};
    tick();
    chk("r1_rinc_off", rsp_fifo_rinc, 0);
    chk("r1_strobes_off", strobes(), 0);
    chk("r1_rxdata_pending", sh_rx_data, 0);
    tick();
    chk("r2_rinc", rsp_fifo_rinc, 1);
    chk("r2_strobes", strobes(), 6'b010000);
    chk("r2_rxdata", sh_rx_data, 32'h12345678);
    rsp_fifo_rdata = {2'd2, 32'h5};
    tick();
    chk("r2_rinc_off", rsp_fifo_rinc, 0);
    tick();
    chk("r3_rinc", rsp_fifo_rinc, 1);
    chk("r3_strobes", strobes(), 6'b001000);
    chk("r3_rxstatus", sh_rx_status, 16'h5);
    chk("r3_txstatus", sh_tx_status, 0);
    rsp_fifo_rdata = {2'd0, 32'hA5};
    tick();
    tick();
    chk("r4_rinc", rsp_fifo_rinc, 1);
    chk("r4_strobes", strobes(), 6'b000100);
    chk("r4_rxconfig", sh_rx_config, 16'hA5);
    chk("r4_txconfig", sh_tx_config, 0);

    // Back to TX, then STATUS and CONFIG land in TX shadows
    rsp_fifo_rdata = {2'd3, 32'hFFFF_FFFE};
    tick();
    tick();
    chk("r5_channel", sh_channel, 0);
    rsp_fifo_rdata = {2'd2, 32'h1};
    tick();
    tick();
    chk("r6_strobes", strobes(), 6'b000010);
    chk("r6_txstatus", sh_tx_status, 1);
    rsp_fifo_rdata = {2'd0, 32'hABCD_1234};
    tick();
    tick();
    chk("r7_strobes", strobes(), 6'b000001);
    chk("r7_txconfig", sh_tx_config, 16'h1234);
    chk("r7_rx_kept", {sh_rx_status, sh_rx_config}, {16'h5, 16'hA5});
    rsp_fifo_empty = 1'b1;
    tick();
    tick();
    chk("r8_idle_rinc", rsp_fifo_rinc, 0);
    chk("r8_idle_strobes", strobes(), 0);

    // Async reset with a held command and a pop in progress
    cmd_valid = 1'b1; cmd_kind = 2'd1; cmd_data = 32'h0BAD_F00D; cmd_fifo_full = 1'b1;
    rsp_fifo_empty = 1'b0; rsp_fifo_rdata = {2'd1, 32'hCAFE_0001};
    tick();
    cmd_valid = 1'b0; rsp_fifo_empty = 1'b1;
    chk("x_pre_ready", cmd_ready, 0);
    chk("x_pre_rinc", rsp_fifo_rinc, 1);
    #2 rst = 1'b1;
    #1;
    chk("x_rinc", rsp_fifo_rinc, 0);
    chk("x_strobes", strobes(), 0);
    chk("x_ready", cmd_ready, 1);
    chk("x_wdata", cmd_fifo_wdata, 0);
    chk("x_shadows", {sh_channel, sh_tx_config, sh_tx_status, sh_rx_config, sh_rx_status}, 0);
    chk("x_rxdata", sh_rx_data, 0);
    cmd_fifo_full = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("x_no_winc", cmd_fifo_winc, 0);
      chk("x_ready_after", cmd_ready, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
